// File: rtl/countdown_pkg.sv
// Shared types, limits and preset clamping helpers for the countdown timer.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [9:0] MS_MAX  = 10'd999;
    localparam logic [5:0] SEC_MAX = 6'd59;

    // Out-of-range seconds saturate to the largest legal value.
    function automatic logic [5:0] clamp_sec(input logic [5:0] v);
        return (v > SEC_MAX) ? SEC_MAX : v;
    endfunction

    // Out-of-range milliseconds saturate to the largest legal value.
    function automatic logic [9:0] clamp_ms(input logic [9:0] v);
        return (v > MS_MAX) ? MS_MAX : v;
    endfunction

endpackage

// File: rtl/countdown_timer_ms_prescaler.sv
// Millisecond tick generator: divides clk by CLK_PER_MS while enabled.
// The counter is held at zero whenever en is low, so every enable period
// starts a fresh millisecond.
module ms_prescaler #(
    parameter int CLK_PER_MS = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_MS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Advance while enabled, wrap after the last cycle of a millisecond.
    always_comb begin
        tick  = en && (cnt_q == CNT_LAST);
        cnt_d = '0;
        if (en && !tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable min:sec:ms countdown timer with one-cycle done pulse and sticky
// expired flag. Optional feature macro: AUTO_RELOAD_EN -- when defined, an
// expiry in RUN reloads the fields from the preset register and keeps running
// (unless the preset is zero).
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int CLK_PER_MS = 1,
    parameter int MIN_W      = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [MIN_W-1:0] load_min,
    input  logic [5:0]       load_sec,
    input  logic [9:0]       load_ms,
    input  logic             start,
    input  logic             stop,
    output logic [9:0]       millisec,
    output logic [5:0]       sec,
    output logic [MIN_W-1:0] min,
    output logic             running,
    output logic             done,
    output logic             expired
);

    state_t           state_q, state_d;
    logic [9:0]       ms_q, ms_d;
    logic [5:0]       sec_q, sec_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [9:0]       pre_ms_q, pre_ms_d;
    logic [5:0]       pre_sec_q, pre_sec_d;
    logic [MIN_W-1:0] pre_min_q, pre_min_d;
    logic             done_q, done_d;
    logic             expired_q, expired_d;

    logic             tick;
    logic             time_zero;
    logic             time_last;
    logic [9:0]       ld_ms;
    logic [5:0]       ld_sec;
    logic [9:0]       dec_ms;
    logic [5:0]       dec_sec;
    logic [MIN_W-1:0] dec_min;

    ms_prescaler #(
        .CLK_PER_MS(CLK_PER_MS)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (state_q == RUN),
        .tick (tick)
    );

    // Time-value predicates and clamped preset inputs.
    always_comb begin
        time_zero = (ms_q == 10'd0) && (sec_q == 6'd0) && (min_q == '0);
        // Zero is treated as "last" too, so a corrupted zero in RUN cannot stall.
        time_last = ((ms_q == 10'd1) || (ms_q == 10'd0)) && (sec_q == 6'd0) && (min_q == '0);
        ld_ms     = clamp_ms(load_ms);
        ld_sec    = clamp_sec(load_sec);
    end

    // Borrow chain: one millisecond less than the current fields, floored at zero.
    always_comb begin
        dec_ms  = ms_q;
        dec_sec = sec_q;
        dec_min = min_q;
        if (ms_q != 10'd0) begin
            dec_ms = ms_q - 10'd1;
        end else if (sec_q != 6'd0) begin
            dec_ms  = MS_MAX;
            dec_sec = sec_q - 6'd1;
        end else if (min_q != '0) begin
            dec_ms  = MS_MAX;
            dec_sec = SEC_MAX;
            dec_min = min_q - MIN_W'(1);
        end
    end

    // FSM next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        ms_d      = ms_q;
        sec_d     = sec_q;
        min_d     = min_q;
        pre_ms_d  = pre_ms_q;
        pre_sec_d = pre_sec_q;
        pre_min_d = pre_min_q;
        done_d    = 1'b0;
        expired_d = expired_q;

        case (state_q)
            RUN: begin
                // load and start are ignored here; stop discards a coincident tick.
                if (stop) begin
                    state_d = PAUSE;
                end else if (tick) begin
                    if (time_last) begin
                        done_d    = 1'b1;
                        expired_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                        if ((pre_ms_q != 10'd0) || (pre_sec_q != 6'd0) || (pre_min_q != '0)) begin
                            ms_d  = pre_ms_q;
                            sec_d = pre_sec_q;
                            min_d = pre_min_q;
                        end else begin
                            ms_d    = '0;
                            sec_d   = '0;
                            min_d   = '0;
                            state_d = DONE;
                        end
`else
                        ms_d    = '0;
                        sec_d   = '0;
                        min_d   = '0;
                        state_d = DONE;
`endif
                    end else begin
                        ms_d  = dec_ms;
                        sec_d = dec_sec;
                        min_d = dec_min;
                    end
                end
            end
            IDLE, PAUSE, DONE: begin
                // A load takes priority over a same-cycle start.
                if (load) begin
                    ms_d      = ld_ms;
                    sec_d     = ld_sec;
                    min_d     = load_min;
                    pre_ms_d  = ld_ms;
                    pre_sec_d = ld_sec;
                    pre_min_d = load_min;
                    expired_d = 1'b0;
                    state_d   = IDLE;
                end else if (start && !stop) begin
                    if (time_zero) begin
                        // Nothing to count: expire straight away.
                        state_d   = DONE;
                        done_d    = 1'b1;
                        expired_d = 1'b1;
                    end else begin
                        state_d   = RUN;
                        expired_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, field, preset and flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ms_q      <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            pre_ms_q  <= '0;
            pre_sec_q <= '0;
            pre_min_q <= '0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ms_q      <= ms_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            pre_ms_q  <= pre_ms_d;
            pre_sec_q <= pre_sec_d;
            pre_min_q <= pre_min_d;
            done_q    <= done_d;
            expired_q <= expired_d;
        end
    end

`ifndef AUTO_RELOAD_EN
    // Single-shot builds keep the preset only for debug visibility.
    logic unused_preset;
    assign unused_preset = ^{pre_min_q, pre_sec_q, pre_ms_q};
`endif

    assign millisec = ms_q;
    assign sec      = sec_q;
    assign min      = min_q;
    assign running  = (state_q == RUN);
    assign done     = done_q;
    assign expired  = expired_q;

endmodule
